// File: rtl/axi_gp_rw_arbiter_if.sv
// Single-beat AXI3 channel bundle between the PS7 MAXIGP0 master and the fabric register bridge.
interface axi_gp_rw_arbiter_if #(parameter int ID_W = 12);
  logic [31:0]     awaddr;
  logic [ID_W-1:0] awid;
  logic [2:0]      awprot;
  logic            awvalid, awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic [ID_W-1:0] wid;
  logic            wvalid, wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [2:0]      arprot;
  logic            arvalid, arready;
  logic [31:0]     rdata;
  logic [ID_W-1:0] rid;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;

  modport slave (
    input  awaddr, awid, awprot, awvalid, output awready,
    input  wdata, wstrb, wid, wvalid,     output wready,
    output bid, bresp, bvalid,            input  bready,
    input  araddr, arid, arprot, arvalid, output arready,
    output rdata, rid, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awaddr, awid, awprot, awvalid, input  awready,
    output wdata, wstrb, wid, wvalid,     input  wready,
    input  bid, bresp, bvalid,            output bready,
    output araddr, arid, arprot, arvalid, input  arready,
    input  rdata, rid, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi_gp_rw_arbiter.sv
// One-at-a-time AXI3 single-beat slave with round-robin AR/AW arbitration onto a register bus.
// Define AXI_TIMEOUT_EN to abort register accesses that see no reg_ack within TIMEOUT cycles.
module axi_gp_rw_arbiter #(
  parameter int ID_W       = 12,
  parameter int REG_ADDR_W = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  fclk,
  input  logic                  reset,
  axi_gp_rw_arbiter_if.slave    ax,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [31:0]           reg_wdata,
  output logic [3:0]            reg_wstrb,
  input  logic                  reg_ack,
  input  logic [31:0]           reg_rdata,
  input  logic                  reg_err
);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t          state, state_d;
  logic            prio;  // 0: read preferred, 1: write preferred
  logic            grant_w, grant_r, id_err, ack_ok, abort;
  logic [ID_W-1:0] bid_q, rid_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [31:0]     rdata_q;

  assign grant_w = ax.awvalid && (!ax.arvalid || prio);
  assign grant_r = ax.arvalid && (!ax.awvalid || !prio);
  assign reg_req = (state == WR_REQ) || (state == RD_REQ);
  assign ack_ok  = reg_req && reg_ack;
  assign id_err  = (ax.wid != bid_q);

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // Fires on the last cycle of the wait window so reg_req stays up exactly TIMEOUT cycles.
  assign abort = reg_req && !reg_ack && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge fclk)
    if (reset || state != state_d) cnt <= '0;
    else if (reg_req)              cnt <= cnt + 1'b1;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    ax.awready = 1'b0;
    ax.arready = 1'b0;
    ax.wready  = 1'b0;
    case (state)
      IDLE: begin
        ax.awready = grant_w;
        ax.arready = grant_r;
        if (grant_w)      state_d = WR_DATA;
        else if (grant_r) state_d = RD_REQ;
      end
      WR_DATA: begin
        ax.wready = 1'b1;
        if (ax.wvalid) state_d = id_err ? WR_RESP : WR_REQ;
      end
      WR_REQ:  if (ack_ok || abort) state_d = WR_RESP;
      WR_RESP: if (ax.bready)       state_d = IDLE;
      RD_REQ:  if (ack_ok || abort) state_d = RD_RESP;
      RD_RESP: if (ax.rready)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      bid_q     <= '0;
      rid_q     <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE:
          if (grant_w) begin
            reg_we   <= 1'b1;
            reg_addr <= ax.awaddr[REG_ADDR_W+1:2];
            bid_q    <= ax.awid;
            prio     <= 1'b0;
          end else if (grant_r) begin
            reg_we   <= 1'b0;
            reg_addr <= ax.araddr[REG_ADDR_W+1:2];
            rid_q    <= ax.arid;
            prio     <= 1'b1;
          end
        WR_DATA:
          if (ax.wvalid) begin
            reg_wdata <= ax.wdata;
            reg_wstrb <= ax.wstrb;
            bresp_q   <= id_err ? 2'b10 : 2'b00;
          end
        WR_REQ:
          if (ack_ok)     bresp_q <= reg_err ? 2'b10 : 2'b00;
          else if (abort) bresp_q <= 2'b10;
        RD_REQ:
          if (ack_ok) begin
            rresp_q <= reg_err ? 2'b10 : 2'b00;
            rdata_q <= reg_err ? 32'h0 : reg_rdata;
          end else if (abort) begin
            rresp_q <= 2'b10;
            rdata_q <= 32'h0;
          end
        default: ;
      endcase
    end
  end

  assign ax.bvalid = (state == WR_RESP);
  assign ax.bid    = bid_q;
  assign ax.bresp  = bresp_q;
  assign ax.rvalid = (state == RD_RESP);
  assign ax.rlast  = ax.rvalid;
  assign ax.rid    = rid_q;
  assign ax.rresp  = rresp_q;
  assign ax.rdata  = rdata_q;

  // Protection bits and sub-word / out-of-window address bits carry no meaning here.
  logic unused;
  assign unused = ^{ax.awprot, ax.arprot,
                    ax.awaddr[31:REG_ADDR_W+2], ax.awaddr[1:0],
                    ax.araddr[31:REG_ADDR_W+2], ax.araddr[1:0]};
endmodule

// File: tb/tb_axi_gp_rw_arbiter.sv
// Directed bench for axi_gp_rw_arbiter: inputs change and outputs are sampled just after the falling edge.
module tb_axi_gp_rw_arbiter;
  localparam int ID_W       = 12;
  localparam int REG_ADDR_W = 8;
  localparam int TIMEOUT    = 64;

  logic                  fclk = 1'b0;
  logic                  reset = 1'b1;
  logic                  reg_req, reg_we, reg_ack, reg_err;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic [31:0]           reg_wdata, reg_rdata;
  logic [3:0]            reg_wstrb;
  int                    checks = 0;
  int                    errors = 0;

  axi_gp_rw_arbiter_if #(.ID_W(ID_W)) ax();

  axi_gp_rw_arbiter #(.ID_W(ID_W), .REG_ADDR_W(REG_ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .fclk      (fclk),
    .reset     (reset),
    .ax        (ax),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wstrb (reg_wstrb),
    .reg_ack   (reg_ack),
    .reg_rdata (reg_rdata),
    .reg_err   (reg_err)
  );

  always #5 fclk = ~fclk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ax.awaddr = '0; ax.awid = '0; ax.awprot = '0; ax.awvalid = 1'b0;
    ax.wdata  = '0; ax.wstrb = '0; ax.wid = '0; ax.wvalid = 1'b0;
    ax.bready = 1'b0;
    ax.araddr = '0; ax.arid = '0; ax.arprot = '0; ax.arvalid = 1'b0;
    ax.rready = 1'b0;
    reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge fclk);
    #1;
    chk("rst_awready", ax.awready, 0);
    chk("rst_arready", ax.arready, 0);
    chk("rst_wready",  ax.wready,  0);
    chk("rst_bvalid",  ax.bvalid,  0);
    chk("rst_rvalid",  ax.rvalid,  0);
    chk("rst_reg_req", reg_req,    0);
    chk("rst_ids",     {ax.bid, ax.rid}, 0);
    chk("rst_resp",    {ax.bresp, ax.rresp}, 0);
    chk("rst_rdata",   ax.rdata,   0);
    chk("rst_reg_bus", {reg_we, reg_addr, reg_wdata, reg_wstrb}, 0);
    reset = 1'b0;
  endtask

  // Entered just after a falling edge; AW and W are offered together, W must wait for AW.
  task automatic axi_write(input logic [31:0] addr, input logic [ID_W-1:0] awid, input logic [ID_W-1:0] wid,
                           input logic [31:0] data, input logic [3:0] strb, input int ack_dly,
                           input logic err, input logic [1:0] exp_bresp, input logic exp_req, input int bp);
    int n;
    logic [REG_ADDR_W-1:0] exp_addr;
    exp_addr = addr[REG_ADDR_W+1:2];
    ax.awaddr = addr; ax.awid = awid; ax.awvalid = 1'b1;
    ax.wdata = data; ax.wstrb = strb; ax.wid = wid; ax.wvalid = 1'b1;
    #1;
    n = 0;
    while (!ax.awready && n < 20) begin @(negedge fclk); #1; n++; end
    chk("aw_ready", ax.awready, 1);
    chk("w_before_aw", ax.wready, 0);
    @(negedge fclk); ax.awvalid = 1'b0; #1;
    chk("wready", ax.wready, 1);
    chk("req_in_wdata", reg_req, 0);
    @(negedge fclk); ax.wvalid = 1'b0; #1;
    if (exp_req) begin
      for (int i = 0; i < ack_dly; i++) begin
        chk("wr_req_hold", reg_req, 1);
        @(negedge fclk); #1;
      end
      chk("wr_req",   reg_req, 1);
      chk("wr_we",    reg_we, 1);
      chk("wr_addr",  reg_addr, exp_addr);
      chk("wr_wdata", reg_wdata, data);
      chk("wr_wstrb", reg_wstrb, strb);
      chk("wr_no_b",  ax.bvalid, 0);
      reg_ack = 1'b1; reg_err = err;
      @(negedge fclk); reg_ack = 1'b0; reg_err = 1'b0; #1;
    end
    chk("bvalid",      ax.bvalid, 1);
    chk("wr_req_drop", reg_req, 0);
    chk("bid",         ax.bid, awid);
    chk("bresp",       ax.bresp, exp_bresp);
    ax.awvalid = (bp > 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge fclk); #1;
      chk("bp_bvalid",  ax.bvalid, 1);
      chk("bp_bid",     ax.bid, awid);
      chk("bp_bresp",   ax.bresp, exp_bresp);
      chk("bp_awready", ax.awready, 0);
    end
    ax.awvalid = 1'b0; ax.bready = 1'b1;
    @(negedge fclk); ax.bready = 1'b0; #1;
    chk("b_done", ax.bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [ID_W-1:0] id, input logic [31:0] rd,
                          input int ack_dly, input logic err, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_rresp);
    int n;
    logic [REG_ADDR_W-1:0] exp_addr;
    exp_addr = addr[REG_ADDR_W+1:2];
    ax.araddr = addr; ax.arid = id; ax.arvalid = 1'b1;
    #1;
    n = 0;
    while (!ax.arready && n < 20) begin @(negedge fclk); #1; n++; end
    chk("ar_ready", ax.arready, 1);
    @(negedge fclk); ax.arvalid = 1'b0; #1;
    for (int i = 0; i < ack_dly; i++) begin
      chk("rd_req_hold", reg_req, 1);
      chk("rd_no_r",     ax.rvalid, 0);
      @(negedge fclk); #1;
    end
    chk("rd_req",  reg_req, 1);
    chk("rd_we",   reg_we, 0);
    chk("rd_addr", reg_addr, exp_addr);
    reg_ack = 1'b1; reg_err = err; reg_rdata = rd;
    @(negedge fclk); reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0; #1;
    chk("rvalid",      ax.rvalid, 1);
    chk("rlast",       ax.rlast, 1);
    chk("rid",         ax.rid, id);
    chk("rdata",       ax.rdata, exp_rdata);
    chk("rresp",       ax.rresp, exp_rresp);
    chk("rd_req_drop", reg_req, 0);
    ax.rready = 1'b1;
    @(negedge fclk); ax.rready = 1'b0; #1;
    chk("r_done", ax.rvalid, 0);
  endtask

  initial begin
    int n;
    do_reset();

    axi_write(32'h4, 12'h5, 12'h5, 32'hDEADBEEF, 4'hF, 0, 1'b0, 2'b00, 1'b1, 0);
    axi_read(32'h8, 12'hA, 32'h12345678, 3, 1'b0, 32'h12345678, 2'b00);
    // Mismatched WID: no register access, SLVERR.
    axi_write(32'h10, 12'h2, 12'h3, 32'h0BADF00D, 4'hF, 0, 1'b0, 2'b10, 1'b0, 0);
    // Register error on read zeroes the data.
    axi_read(32'h20, 12'h7, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 2'b10);
    // Zero strobes pass through, register error, B held off for 5 cycles.
    axi_write(32'h3FC, 12'hABC, 12'hABC, 32'h000055AA, 4'h0, 2, 1'b1, 2'b10, 1'b1, 5);

    // Both channels held valid: fresh reset favours read, then alternates.
    do_reset();
    ax.awaddr = 32'h40; ax.awid = 12'h1; ax.wid = 12'h1; ax.wdata = 32'h1; ax.wstrb = 4'hF;
    ax.araddr = 32'h80; ax.arid = 12'h2;
    ax.awvalid = 1'b1; ax.wvalid = 1'b1; ax.arvalid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("arb_ar", ax.arready, (t % 2 == 0));
      chk("arb_aw", ax.awready, (t % 2 == 1));
      @(negedge fclk);
      if (t % 2 == 0) begin
        reg_ack = 1'b1; reg_rdata = 32'h100 + t;
        @(negedge fclk); reg_ack = 1'b0; ax.rready = 1'b1; #1;
        chk("arb_rvalid", ax.rvalid, 1);
        chk("arb_rdata",  ax.rdata, 32'h100 + t);
        @(negedge fclk); ax.rready = 1'b0;
      end else begin
        @(negedge fclk); reg_ack = 1'b1;
        @(negedge fclk); reg_ack = 1'b0; ax.bready = 1'b1; #1;
        chk("arb_bvalid", ax.bvalid, 1);
        @(negedge fclk); ax.bready = 1'b0;
      end
    end
    idle_inputs();

    // Reset while the read is waiting on the register bus.
    ax.araddr = 32'hC; ax.arid = 12'h3; ax.arvalid = 1'b1;
    @(negedge fclk); ax.arvalid = 1'b0; #1;
    chk("mid_req", reg_req, 1);
    reset = 1'b1;
    @(negedge fclk); #1;
    chk("mid_rst_req",    reg_req, 0);
    chk("mid_rst_rvalid", ax.rvalid, 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge fclk); #1;
      chk("mid_no_resp", {ax.rvalid, ax.bvalid, reg_req}, 0);
    end

`ifdef AXI_TIMEOUT_EN
    ax.araddr = 32'h30; ax.arid = 12'h9; ax.arvalid = 1'b1;
    @(negedge fclk); ax.arvalid = 1'b0; #1;
    n = 0;
    while (reg_req && n < 200) begin n++; @(negedge fclk); #1; end
    chk("to_cycles", n, TIMEOUT);
    chk("to_rvalid", ax.rvalid, 1);
    chk("to_rid",    ax.rid, 12'h9);
    chk("to_rresp",  ax.rresp, 2'b10);
    chk("to_rdata",  ax.rdata, 0);
    ax.rready = 1'b1;
    @(negedge fclk); ax.rready = 1'b0;
    reg_ack = 1'b1; reg_rdata = 32'hCAFEF00D;
    @(negedge fclk); reg_ack = 1'b0; reg_rdata = '0;
    repeat (3) begin
      #1;
      chk("to_late_ack", {ax.rvalid, ax.bvalid, reg_req}, 0);
      @(negedge fclk);
    end
`endif

    n = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
